// File: rtl/hdb3_b_insert.sv
// hdb3_b_insert
//
// Back end of the HDB3 encoder. Takes the V-marked symbol stream from the
// V-insertion stage and delays it through a four-entry buffer. When a V
// arrives and an even number of marks has been seen since the previous V,
// the zero three symbols ahead of it becomes a B pulse. The block then
// applies alternate-mark polarity and drives the two line rails.
//
// Symbol encoding: 00 = zero, 01 = one (mark), 11 = V, 10 = B.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         clock enable; when low every register holds its value
//   data_in_v  symbol from the V-insertion stage (00, 01, 11 legal)
//   data_out_b symbol after B substitution, 5 enabled edges after input
//   code_p     positive-rail pulse, one register after data_out_b
//   code_n     negative-rail pulse, one register after data_out_b
//   out_valid  high once the pipeline holds post-reset symbols
//   code_err   sticky flag, set when an illegal 10 is accepted

module hdb3_b_insert (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] data_in_v,
    output logic [1:0] data_out_b,
    output logic       code_p,
    output logic       code_n,
    output logic       out_valid,
    output logic       code_err
);

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_ONE  = 2'b01;
    localparam logic [1:0] SYM_B    = 2'b10;
    localparam logic [1:0] SYM_V    = 2'b11;

    localparam logic [2:0] FILL_DONE = 3'd5;

    logic [1:0] sr [0:3];
    logic       parity;
    logic       last_pol;
    logic [2:0] fill_cnt;

    logic [1:0] accepted_sym;
    logic       insert_b;
    logic       next_p;
    logic       next_n;
    logic       next_pol;

    // An illegal B code on the input is neutralised to a zero. A V seen with
    // even parity forces a B onto the symbol moving from sr[2] into sr[3],
    // which is the zero accepted three enabled cycles before the V.
    always_comb begin
        accepted_sym = (data_in_v == SYM_B) ? SYM_ZERO : data_in_v;
        insert_b     = (data_in_v == SYM_V) && !parity;
    end

    // Four-entry delay buffer plus the output symbol register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr[0]      <= SYM_ZERO;
            sr[1]      <= SYM_ZERO;
            sr[2]      <= SYM_ZERO;
            sr[3]      <= SYM_ZERO;
            data_out_b <= SYM_ZERO;
        end else if (en) begin
            sr[0]      <= accepted_sym;
            sr[1]      <= sr[0];
            sr[2]      <= sr[1];
            sr[3]      <= insert_b ? SYM_B : sr[2];
            data_out_b <= sr[3];
        end
    end

    // Mark parity since the last V. The B decision above reads the old value,
    // so clearing here on a V takes effect for the next V only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (en) begin
            if (data_in_v == SYM_V) begin
                parity <= 1'b0;
            end else if (data_in_v == SYM_ONE) begin
                parity <= ~parity;
            end
        end
    end

    // Sticky illegal-code flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_err <= 1'b0;
        end else if (en && (data_in_v == SYM_B)) begin
            code_err <= 1'b1;
        end
    end

    // Pipeline fill counter, saturating once the buffer and output register
    // hold only post-reset symbols.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= 3'd0;
        end else if (en && (fill_cnt != FILL_DONE)) begin
            fill_cnt <= fill_cnt + 3'd1;
        end
    end

    assign out_valid = (fill_cnt == FILL_DONE);

    // Alternate-mark polarity: marks and B pulses go opposite to the last
    // pulse and flip the polarity; V repeats the last polarity, which is the
    // deliberate bipolar violation.
    always_comb begin
        next_p   = 1'b0;
        next_n   = 1'b0;
        next_pol = last_pol;
        case (data_out_b)
            SYM_ONE, SYM_B: begin
                next_p   = !last_pol;
                next_n   = last_pol;
                next_pol = !last_pol;
            end
            SYM_V: begin
                next_p = last_pol;
                next_n = !last_pol;
            end
            default: begin
                next_p = 1'b0;
                next_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_p   <= 1'b0;
            code_n   <= 1'b0;
            last_pol <= 1'b0;
        end else if (en) begin
            code_p   <= next_p;
            code_n   <= next_n;
            last_pol <= next_pol;
        end
    end

endmodule

// File: tb/tb_hdb3_b_insert.sv
// Testbench for hdb3_b_insert: directed symbol streams with hand-computed
// expected symbols and rails, checked after every clock edge.

module tb_hdb3_b_insert;

    localparam logic [1:0] P = 2'b10;
    localparam logic [1:0] N = 2'b01;
    localparam logic [1:0] Z = 2'b00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] data_in_v = 2'b00;
    logic [1:0] data_out_b;
    logic       code_p;
    logic       code_n;
    logic       out_valid;
    logic       code_err;

    int testsRun = 0;
    int testsFailed = 0;

    logic [1:0] stim [0:15];
    logic [1:0] expB [0:15];
    logic [1:0] expR [0:15];

    always #5 clk = ~clk;

    hdb3_b_insert dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .data_in_v (data_in_v),
        .data_out_b(data_out_b),
        .code_p    (code_p),
        .code_n    (code_n),
        .out_valid (out_valid),
        .code_err  (code_err)
    );

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic setVec(input int idx, input logic [1:0] s, input logic [1:0] b, input logic [1:0] r);
        stim[idx] = s;
        expB[idx] = b;
        expR[idx] = r;
    endtask

    function automatic logic [1:0] expectedB(input int k, input int n);
        return (k >= 5 && k - 5 < n) ? expB[k-5] : 2'b00;
    endfunction

    function automatic logic [1:0] expectedR(input int k, input int n);
        return (k >= 6 && k - 6 < n) ? expR[k-6] : 2'b00;
    endfunction

    task automatic checkAll(input string phase, input int k, input int n, input int errEdge);
        checkOutput($sformatf("%s data_out_b k=%0d", phase, k), {6'd0, data_out_b}, {6'd0, expectedB(k, n)});
        checkOutput($sformatf("%s rails k=%0d", phase, k), {6'd0, code_p, code_n}, {6'd0, expectedR(k, n)});
        checkOutput($sformatf("%s out_valid k=%0d", phase, k), {7'd0, out_valid}, {7'd0, (k >= 5)});
        checkOutput($sformatf("%s code_err k=%0d", phase, k), {7'd0, code_err},
                    {7'd0, (errEdge != 0 && k >= errEdge)});
    endtask

    task automatic checkZero(input string phase);
        checkOutput({phase, " data_out_b"}, {6'd0, data_out_b}, 8'd0);
        checkOutput({phase, " rails"}, {6'd0, code_p, code_n}, 8'd0);
        checkOutput({phase, " out_valid"}, {7'd0, out_valid}, 8'd0);
        checkOutput({phase, " code_err"}, {7'd0, code_err}, 8'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        data_in_v = 2'b00;
        #1;
        checkZero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs 'total' enabled cycles feeding stim[0..n-1] then zeros. In gapped
    // mode every enabled cycle is preceded by an en=0 cycle carrying junk
    // symbols, during which outputs must hold.
    task automatic applyStimulus(input int n, input bit gapped, input int errEdge, input int total);
        int k = 0;
        for (int i = 0; i < total; i++) begin
            if (gapped) begin
                en = 1'b0;
                data_in_v = (i % 2 == 1) ? 2'b11 : 2'b10;
                @(posedge clk);
                @(negedge clk);
                checkAll("hold", k, n, errEdge);
            end
            en = 1'b1;
            data_in_v = (i < n) ? stim[i] : 2'b00;
            @(posedge clk);
            @(negedge clk);
            k++;
            checkAll("run", k, n, errEdge);
        end
        en = 1'b0;
        data_in_v = 2'b00;
    endtask

    task automatic loadCase1();
        setVec(0, 2'b00, 2'b10, P);
        setVec(1, 2'b00, 2'b00, Z);
        setVec(2, 2'b00, 2'b00, Z);
        setVec(3, 2'b11, 2'b11, P);
        setVec(4, 2'b00, 2'b10, N);
        setVec(5, 2'b00, 2'b00, Z);
        setVec(6, 2'b00, 2'b00, Z);
        setVec(7, 2'b11, 2'b11, N);
    endtask

    initial begin
        // Two B/V groups from reset.
        doReset();
        loadCase1();
        applyStimulus(8, 1'b0, 0, 14);

        // Odd parity: no B before the V.
        doReset();
        setVec(0, 2'b01, 2'b01, P);
        setVec(1, 2'b00, 2'b00, Z);
        setVec(2, 2'b00, 2'b00, Z);
        setVec(3, 2'b00, 2'b00, Z);
        setVec(4, 2'b11, 2'b11, P);
        applyStimulus(5, 1'b0, 0, 11);

        // Even parity: B inserted.
        doReset();
        setVec(0, 2'b01, 2'b01, P);
        setVec(1, 2'b01, 2'b01, N);
        setVec(2, 2'b00, 2'b10, P);
        setVec(3, 2'b00, 2'b00, Z);
        setVec(4, 2'b00, 2'b00, Z);
        setVec(5, 2'b11, 2'b11, P);
        applyStimulus(6, 1'b0, 0, 12);

        // First case again with en gaps.
        doReset();
        loadCase1();
        applyStimulus(8, 1'b1, 0, 14);

        // Illegal code becomes a zero and sets the sticky error flag.
        doReset();
        setVec(0, 2'b01, 2'b01, P);
        setVec(1, 2'b10, 2'b00, Z);
        setVec(2, 2'b00, 2'b00, Z);
        setVec(3, 2'b01, 2'b01, N);
        applyStimulus(4, 1'b0, 2, 12);

        // Reset two cycles after a V is accepted, then restart cleanly.
        doReset();
        setVec(0, 2'b00, 2'b10, P);
        setVec(1, 2'b00, 2'b00, Z);
        setVec(2, 2'b00, 2'b00, Z);
        setVec(3, 2'b11, 2'b11, P);
        setVec(4, 2'b00, 2'b00, Z);
        setVec(5, 2'b00, 2'b00, Z);
        applyStimulus(6, 1'b0, 0, 6);
        #2;
        rst_n = 1'b0;
        #1;
        checkZero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        loadCase1();
        applyStimulus(4, 1'b0, 0, 10);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
